// File: rtl/ram_param_pkg.sv
// +--------------------------------------------------------------------+
// | Module      : ram_param_pkg                                        |
// | Description : Shared definitions for the parametrised RAM: clear   |
// |               engine state encoding, default geometry, legacy      |
// |               RAM8..RAM16K address-width aliases, depth helper.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

package ram_param_pkg;

   // Clear engine states, 2-bit encoding shared by controller and top.
   typedef enum logic [1:0] {
      ST_CLEAR = 2'b00,
      ST_IDLE  = 2'b01
   } ram_state_e;

   // Default geometry: 16-bit words, 16K deep (the RAM16K footprint).
   localparam int unsigned C_DEF_WIDTH  = 16;
   localparam int unsigned C_DEF_ADDR_W = 14;

   // Address widths of the legacy fixed-size chips this block replaces.
   typedef enum int unsigned {
      AW_RAM8   = 3,
      AW_RAM64  = 6,
      AW_RAM512 = 9,
      AW_RAM4K  = 12,
      AW_RAM16K = 14
   } legacy_aw_e;

   // Number of words addressed by an address bus of the given width.
   function automatic int unsigned depth_of(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage : ram_param_pkg

`default_nettype wire

// File: rtl/ram_clear_ctrl.sv
// +--------------------------------------------------------------------+
// | Module      : ram_clear_ctrl                                       |
// | Description : Clear engine for ram_param. Holds the CLEAR/IDLE     |
// |               state and the sweep pointer, and presents a write    |
// |               port that stamps every word with the clear value.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module ram_clear_ctrl
   import ram_param_pkg::*;
#(
   parameter int unsigned ADDR_W = C_DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   output logic              busy_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   // Pointer terminal value is DEPTH-1, i.e. all ones; no overflow bit.
   localparam logic [ADDR_W-1:0] C_PTR_LAST = '1;
   localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);

   ram_state_e        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q,   ptr_d;

   // State and pointer registers; reset parks the engine at the start of a sweep.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state: sweep one word per edge, a clear request always restarts at 0.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_CLEAR: begin
            if (clear_i) begin
               ptr_d = '0;
            end else if (ptr_q == C_PTR_LAST) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + C_PTR_ONE;
            end
         end
         ST_IDLE: begin
            if (clear_i) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   // Any non-IDLE encoding is treated as busy so a corrupted state never
   // exposes the user port before a full sweep.
   assign busy_o     = (state_q != ST_IDLE);
   // Memory is left untouched on edges where reset is asserted.
   assign clr_we_o   = busy_o & rst_n;
   assign clr_addr_o = ptr_q;

endmodule : ram_clear_ctrl

`default_nettype wire

// File: rtl/ram_param.sv
// +--------------------------------------------------------------------+
// | Module      : ram_param                                            |
// | Description : WIDTH x 2**ADDR_W single-port RAM with Hack-style    |
// |               load/address/out contract, synchronous reset and a   |
// |               hardware clear engine (busy while sweeping).         |
// |               Build option RAM_REGOUT_EN: registered read port     |
// |               (one-cycle latency, read-first); otherwise the read  |
// |               is combinational.                                    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module ram_param
   import ram_param_pkg::*;
#(
   parameter int unsigned      WIDTH     = C_DEF_WIDTH,
   parameter int unsigned      ADDR_W    = C_DEF_ADDR_W,
   parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic [WIDTH-1:0]  in_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] address_i,
   output logic [WIDTH-1:0]  out_o,
   output logic              busy_o
);

   localparam int unsigned DEPTH = depth_of(ADDR_W);

   logic [WIDTH-1:0]  mem_q [DEPTH];

   logic              busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_wdata;

   ram_clear_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_clear_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (clear_i),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // The clear engine owns the write port while busy; in IDLE a clear
   // request takes priority and drops a simultaneous user write.
   assign mem_we    = clr_we | (rst_n & ~busy & load_i & ~clear_i);
   assign mem_addr  = busy ? clr_addr  : address_i;
   assign mem_wdata = busy ? CLEAR_VAL : in_i;

   // Storage: no reset, contents are only ever exposed after a full sweep.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_addr] <= mem_wdata;
      end
   end

`ifdef RAM_REGOUT_EN
   logic [WIDTH-1:0] out_q, out_d;

   // Read data for the next cycle; mem_q still holds pre-write data here,
   // giving read-first behaviour on a same-address write.
   always_comb begin
      out_d = mem_q[address_i];
      if (busy || clear_i) begin
         out_d = CLEAR_VAL;
      end
   end

   // Registered read port, forced to the clear value under reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q <= CLEAR_VAL;
      end else begin
         out_q <= out_d;
      end
   end

   assign out_o = out_q;
`else
   // Zero-latency read, identical to the legacy chips once IDLE.
   assign out_o = busy ? CLEAR_VAL : mem_q[address_i];
`endif

   assign busy_o = busy;

endmodule : ram_param

`default_nettype wire
